// File: rtl/morse_keyer_seq_if.sv
// Character handshake and keyer status bundle between a message source and morse_keyer_seq.
interface morse_keyer_seq_if;
    logic       iVALID;
    logic [5:0] iCHAR;
    logic       oREADY;
    logic       oBUSY;
    logic       oKEY;
    logic       oSOUND;
    logic       oERR;

    modport master (
        output iVALID, iCHAR,
        input  oREADY, oBUSY, oKEY, oSOUND, oERR
    );

    modport slave (
        input  iVALID, iCHAR,
        output oREADY, oBUSY, oKEY, oSOUND, oERR
    );
endinterface

// File: rtl/morse_keyer_seq.sv
// Morse keyer: accepts one character code at a time, looks it up in a Morse ROM and
// times marks/gaps in dot units, gating a free-running tone onto the speaker.
module morse_keyer_seq #(
    parameter int unsigned UNIT_CYCLES = 6250000,
    parameter int unsigned TONE_BIT    = 17,
    parameter int unsigned CNT_W       = 26
) (
    input  logic              iCLK,
    input  logic              iRST,
    morse_keyer_seq_if.slave  bus
);
    localparam int unsigned TONE_W = TONE_BIT + 1;
    localparam logic [CNT_W-1:0] DOT_LOAD  = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DASH_LOAD = CNT_W'(3 * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WGAP_LOAD = CNT_W'(4 * UNIT_CYCLES - 1);
    localparam logic [5:0]       WORD_SPACE = 6'd63;

    typedef enum logic [2:0] {IDLE, MARK, GAP, LGAP, WGAP} stateType;

    stateType          state, stateNext;
    logic [CNT_W-1:0]  cnt, cntNext;
    logic [4:0]        pat, patNext;
    logic [2:0]        elemLeft, elemNext;
    logic [TONE_W-1:0] toneCnt;
    logic              keyReg, keyNext;
    logic              busyReg;
    logic              errReg, errNext;
    logic [2:0]        romLen;
    logic [4:0]        romPat;
    logic              cntDone;

    // Morse ROM: length and left-aligned pattern, first element in bit 4, 1 = dash; length 0 = invalid
    always_comb begin
        {romLen, romPat} = 8'd0;
        case (bus.iCHAR)
            6'd0:  {romLen, romPat} = {3'd2, 5'b01000};
            6'd1:  {romLen, romPat} = {3'd4, 5'b10000};
            6'd2:  {romLen, romPat} = {3'd4, 5'b10100};
            6'd3:  {romLen, romPat} = {3'd3, 5'b10000};
            6'd4:  {romLen, romPat} = {3'd1, 5'b00000};
            6'd5:  {romLen, romPat} = {3'd4, 5'b00100};
            6'd6:  {romLen, romPat} = {3'd3, 5'b11000};
            6'd7:  {romLen, romPat} = {3'd4, 5'b00000};
            6'd8:  {romLen, romPat} = {3'd2, 5'b00000};
            6'd9:  {romLen, romPat} = {3'd4, 5'b01110};
            6'd10: {romLen, romPat} = {3'd3, 5'b10100};
            6'd11: {romLen, romPat} = {3'd4, 5'b01000};
            6'd12: {romLen, romPat} = {3'd2, 5'b11000};
            6'd13: {romLen, romPat} = {3'd2, 5'b10000};
            6'd14: {romLen, romPat} = {3'd3, 5'b11100};
            6'd15: {romLen, romPat} = {3'd4, 5'b01100};
            6'd16: {romLen, romPat} = {3'd4, 5'b11010};
            6'd17: {romLen, romPat} = {3'd3, 5'b01000};
            6'd18: {romLen, romPat} = {3'd3, 5'b00000};
            6'd19: {romLen, romPat} = {3'd1, 5'b10000};
            6'd20: {romLen, romPat} = {3'd3, 5'b00100};
            6'd21: {romLen, romPat} = {3'd4, 5'b00010};
            6'd22: {romLen, romPat} = {3'd3, 5'b01100};
            6'd23: {romLen, romPat} = {3'd4, 5'b10010};
            6'd24: {romLen, romPat} = {3'd4, 5'b10110};
            6'd25: {romLen, romPat} = {3'd4, 5'b11000};
            6'd26: {romLen, romPat} = {3'd5, 5'b11111};
            6'd27: {romLen, romPat} = {3'd5, 5'b01111};
            6'd28: {romLen, romPat} = {3'd5, 5'b00111};
            6'd29: {romLen, romPat} = {3'd5, 5'b00011};
            6'd30: {romLen, romPat} = {3'd5, 5'b00001};
            6'd31: {romLen, romPat} = {3'd5, 5'b00000};
            6'd32: {romLen, romPat} = {3'd5, 5'b10000};
            6'd33: {romLen, romPat} = {3'd5, 5'b11000};
            6'd34: {romLen, romPat} = {3'd5, 5'b11100};
            6'd35: {romLen, romPat} = {3'd5, 5'b11110};
            default: {romLen, romPat} = 8'd0;
        endcase
    end

    assign cntDone = (cnt == '0);

    // Next-state, duration reload and element bookkeeping
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        patNext   = pat;
        elemNext  = elemLeft;
        errNext   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.iVALID) begin
                    if (bus.iCHAR == WORD_SPACE) begin
                        stateNext = WGAP;
                        cntNext   = WGAP_LOAD;
                    end else if (romLen != 3'd0) begin
                        stateNext = MARK;
                        patNext   = romPat;
                        elemNext  = romLen;
                        cntNext   = romPat[4] ? DASH_LOAD : DOT_LOAD;
                    end else begin
                        errNext = 1'b1;
                    end
                end
            end
            MARK: begin
                if (cntDone) begin
                    patNext  = {pat[3:0], 1'b0};
                    elemNext = elemLeft - 3'd1;
                    if (elemLeft == 3'd1) begin
                        stateNext = LGAP;
                        cntNext   = DASH_LOAD;
                    end else begin
                        stateNext = GAP;
                        cntNext   = DOT_LOAD;
                    end
                end else begin
                    cntNext = cnt - CNT_W'(1);
                end
            end
            GAP: begin
                if (cntDone) begin
                    stateNext = MARK;
                    cntNext   = pat[4] ? DASH_LOAD : DOT_LOAD;
                end else begin
                    cntNext = cnt - CNT_W'(1);
                end
            end
            LGAP, WGAP: begin
                if (cntDone) begin
                    stateNext = IDLE;
                end else begin
                    cntNext = cnt - CNT_W'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
        keyNext = (stateNext == MARK);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state    <= IDLE;
            cnt      <= '0;
            pat      <= '0;
            elemLeft <= '0;
            toneCnt  <= '0;
            keyReg   <= 1'b0;
            busyReg  <= 1'b0;
            errReg   <= 1'b0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            pat      <= patNext;
            elemLeft <= elemNext;
            toneCnt  <= toneCnt + TONE_W'(1);
            keyReg   <= keyNext;
            busyReg  <= (stateNext != IDLE);
            errReg   <= errNext;
        end
    end

    assign bus.oREADY = (state == IDLE);
    assign bus.oBUSY  = busyReg;
    assign bus.oKEY   = keyReg;
    assign bus.oSOUND = keyReg & toneCnt[TONE_BIT];
    assign bus.oERR   = errReg;
endmodule

// File: tb/tb_morse_keyer_seq.sv
// Randomized bench for morse_keyer_seq against a per-cycle waveform model built from Morse strings.
module tb_morse_keyer_seq;
    localparam int unsigned UNIT = 4;
    localparam int unsigned TB   = 2;
    localparam int unsigned CW   = 8;

    typedef struct packed {
        logic ready;
        logic busy;
        logic key;
        logic err;
    } expType;

    localparam expType IDLE_EXP = '{ready: 1'b1, busy: 1'b0, key: 1'b0, err: 1'b0};
    localparam expType BUSY_OFF = '{ready: 1'b0, busy: 1'b1, key: 1'b0, err: 1'b0};
    localparam expType BUSY_ON  = '{ready: 1'b0, busy: 1'b1, key: 1'b1, err: 1'b0};
    localparam expType ERR_EXP  = '{ready: 1'b1, busy: 1'b0, key: 1'b0, err: 1'b1};

    logic iCLK = 1'b0;
    logic iRST;
    always #5 iCLK = ~iCLK;

    morse_keyer_seq_if bus ();

    morse_keyer_seq #(.UNIT_CYCLES(UNIT), .TONE_BIT(TB), .CNT_W(CW)) dut (
        .iCLK(iCLK),
        .iRST(iRST),
        .bus (bus)
    );

    string morseTbl [36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."
    };

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int unsigned toneRef = 0;
    bit          xfer;
    expType      cur;
    expType      expQ [$];

    // Expected per-cycle waveform of one accepted code, starting with the cycle after the transfer
    function automatic void pushChar(input logic [5:0] c);
        string s;
        int    n;
        if (c == 6'd63) begin
            for (int i = 0; i < 4 * UNIT; i++) expQ.push_back(BUSY_OFF);
        end else if (c < 6'd36) begin
            s = morseTbl[c];
            for (int e = 0; e < s.len(); e++) begin
                n = (s[e] == "-") ? 3 : 1;
                for (int i = 0; i < n * int'(UNIT); i++) expQ.push_back(BUSY_ON);
                if (e < s.len() - 1)
                    for (int i = 0; i < UNIT; i++) expQ.push_back(BUSY_OFF);
            end
            for (int i = 0; i < 3 * UNIT; i++) expQ.push_back(BUSY_OFF);
        end else begin
            expQ.push_back(ERR_EXP);
        end
    endfunction

    // One clock: drive inputs, advance the model on the edge, compare all outputs mid-cycle
    task automatic step(input logic v, input logic [5:0] c, input logic r);
        logic [4:0] got, want;
        bus.iVALID = v;
        bus.iCHAR  = c;
        iRST       = r;
        @(posedge iCLK);
        cyc++;
        xfer = !r && v && (cur.ready === 1'b1);
        if (r) begin
            expQ.delete();
            toneRef = 0;
        end else begin
            toneRef++;
            if (xfer) pushChar(c);
        end
        cur = (expQ.size() > 0) ? expQ.pop_front() : IDLE_EXP;
        @(negedge iCLK);
        got  = {bus.oREADY, bus.oBUSY, bus.oKEY, bus.oERR, bus.oSOUND};
        want = {cur.ready, cur.busy, cur.key, cur.err, cur.key & toneRef[TB]};
        checks++;
        if (got !== want) begin
            errors++;
            if (errors < 30)
                $display("FAIL outputs cyc=%0d rdy/busy/key/err/snd got=%b exp=%b", cyc, got, want);
        end
    endtask

    task automatic sendChar(input logic [5:0] c, output int tXfer);
        tXfer = -1;
        for (int i = 0; i < 300 && tXfer < 0; i++) begin
            step(1'b1, c, 1'b0);
            if (xfer) tXfer = cyc;
        end
        checks++;
        if (tXfer < 0) begin
            errors++;
            $display("FAIL handshake_timeout code=%0d not accepted in 300 cycles", c);
        end
    endtask

    // Idle until ready; returns the ready cycle relative to edge t0 (transfer edge = cycle 0)
    task automatic waitReady(input int t0, output int readyRel, output int keyCnt);
        keyCnt   = int'(bus.oKEY);
        readyRel = -1;
        for (int i = 0; i < 300 && bus.oREADY !== 1'b1; i++) begin
            step(1'b0, 6'($urandom), 1'b0);
            keyCnt += int'(bus.oKEY);
        end
        checks++;
        if (bus.oREADY !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout got=%b exp=1", bus.oREADY);
        end else begin
            readyRel = cyc - t0 + 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 6'($urandom), 1'b0);
    endtask

    task automatic test_reset;
        step(1'b1, 6'd4, 1'b1);
        step(1'b0, 6'd0, 1'b1);
        checks++;
        if ({bus.oREADY, bus.oBUSY, bus.oKEY, bus.oSOUND, bus.oERR} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_state got=%b exp=10000",
                     {bus.oREADY, bus.oBUSY, bus.oKEY, bus.oSOUND, bus.oERR});
        end
        idle(2);
    endtask

    task automatic test_letter_e;
        int t, rel, keys;
        sendChar(6'd4, t);
        waitReady(t, rel, keys);
        checks++;
        if (rel !== 17) begin errors++; $display("FAIL e_ready_cycle got=%0d exp=17", rel); end
        checks++;
        if (keys !== int'(UNIT)) begin errors++; $display("FAIL e_key_cycles got=%0d exp=%0d", keys, UNIT); end
    endtask

    task automatic test_back_to_back;
        int t1, t2, rel, keys;
        sendChar(6'd18, t1);
        sendChar(6'd14, t2);
        checks++;
        if (t2 - t1 !== 33) begin errors++; $display("FAIL so_second_xfer got=%0d exp=33", t2 - t1); end
        waitReady(t1, rel, keys);
        checks++;
        if (rel !== 90) begin errors++; $display("FAIL so_ready_cycle got=%0d exp=90", rel); end
    endtask

    task automatic test_word_space;
        int t1, t2, rel, keys;
        sendChar(6'd19, t1);
        sendChar(6'd63, t2);
        checks++;
        if (t2 - t1 !== 25) begin errors++; $display("FAIL t_space_xfer got=%0d exp=25", t2 - t1); end
        waitReady(t1, rel, keys);
        checks++;
        if (rel !== 42 || keys !== 0) begin
            errors++;
            $display("FAIL space_ready_keys got=%0d/%0d exp=42/0", rel, keys);
        end
    endtask

    task automatic test_invalid;
        int t1, t2, rel, keys;
        sendChar(6'd40, t1);
        checks++;
        if ({bus.oERR, bus.oBUSY, bus.oKEY, bus.oREADY} !== 4'b1001) begin
            errors++;
            $display("FAIL invalid_cycle1 err/busy/key/rdy got=%b exp=1001",
                     {bus.oERR, bus.oBUSY, bus.oKEY, bus.oREADY});
        end
        sendChar(6'd4, t2);
        checks++;
        if (t2 - t1 !== 1 || bus.oERR !== 1'b0) begin
            errors++;
            $display("FAIL invalid_then_e xfer_gap/err got=%0d/%b exp=1/0", t2 - t1, bus.oERR);
        end
        waitReady(t2, rel, keys);
    endtask

    task automatic test_digit_zero;
        int t, rel, keys;
        sendChar(6'd26, t);
        waitReady(t, rel, keys);
        checks++;
        if (rel !== 89 || keys !== 60) begin
            errors++;
            $display("FAIL zero_ready_keys got=%0d/%0d exp=89/60", rel, keys);
        end
    endtask

    task automatic test_reset_mid_dash;
        int t1, t2, rel, keys;
        sendChar(6'd19, t1);
        idle(5);
        step(1'b1, 6'd4, 1'b1);
        checks++;
        if ({bus.oKEY, bus.oBUSY, bus.oREADY} !== 3'b001) begin
            errors++;
            $display("FAIL reset_mid_dash key/busy/rdy got=%b exp=001", {bus.oKEY, bus.oBUSY, bus.oREADY});
        end
        sendChar(6'd4, t2);
        checks++;
        if (t2 - t1 !== 7) begin errors++; $display("FAIL reset_then_e_xfer got=%0d exp=7", t2 - t1); end
        waitReady(t2, rel, keys);
        checks++;
        if (rel !== 17 || keys !== int'(UNIT)) begin
            errors++;
            $display("FAIL reset_then_e_timing got=%0d/%0d exp=17/%0d", rel, keys, UNIT);
        end
    endtask

    task automatic test_random;
        int        t, r;
        logic [5:0] c;
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70)      c = 6'($urandom_range(0, 35));
            else if (r < 80) c = 6'd63;
            else             c = 6'($urandom_range(36, 62));
            sendChar(c, t);
            if ($urandom_range(0, 19) == 0) begin
                idle(int'($urandom_range(0, 20)));
                step(1'b1, 6'($urandom), 1'b1);
            end
            idle(int'($urandom_range(0, 3)));
        end
        idle(100);
    endtask

    initial begin
        bus.iVALID = 1'b0;
        bus.iCHAR  = 6'd0;
        iRST       = 1'b1;
        cur        = IDLE_EXP;
        test_reset();
        test_letter_e();
        test_back_to_back();
        test_word_space();
        test_invalid();
        test_digit_zero();
        test_reset_mid_dash();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
